fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter n, default 32: PC/address and datapath width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory request.
REQ-006 imem_addr  output  n  byte address of the requested instruction.
REQ-007 imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-008 imem_ack  input  1  memory completes the request this cycle.
REQ-009 instr_valid  output  1  held instruction is available to the decoder.
REQ-010 instr_ready  input  1  decoder/datapath consumes the held instruction this cycle.
REQ-011 instr  output  32  held instruction word.
REQ-012 op  output  6  instr[31:26].
REQ-013 funct  output  6  instr[5:0].
REQ-014 pc  output  n  address of the held instruction.
REQ-015 pcplus4  output  n  pc + 4.
REQ-016 pcsrc, jump, jumpreg  input  1 each  redirect controls for the held instruction.
REQ-017 signimm  input  n  sign-extended immediate for the branch target.
REQ-018 rs_data  input  n  register value for the jump-register target.
REQ-019 fetch_err  output  1  sticky misaligned-target error.

Function
REQ-020 The FSM SHALL have three states: FETCH, HOLD, ERROR.
REQ-021 In FETCH: imem_req=1, and imem_addr SHALL equal the fetch PC and stay stable until imem_ack.
REQ-022 In FETCH with imem_ack=1: latch imem_rdata into instr, latch the fetch PC into pc, and go to HOLD. instr_valid SHALL rise exactly 1 cycle after ack.
REQ-023 In HOLD: imem_req=0 and instr_valid=1. instr, pc, op and funct SHALL stay stable until consumed.
REQ-024 In HOLD with instr_ready=1: compute the next PC, load it as the fetch PC, and go to FETCH.
REQ-025 Next-PC priority SHALL be: jumpreg -> rs_data; else jump -> {pcplus4[n-1:28], instr[25:0], 2'b00}; else pcsrc -> pcplus4 + (signimm << 2); else pcplus4.
REQ-026 All arithmetic SHALL be modulo 2^n. 32'hFFFF_FFFC + 4 wraps to 0.
REQ-027 If the selected next PC has bits [1:0] != 0: go to ERROR instead of FETCH, set fetch_err=1, and latch the bad address into pc.
REQ-028 ERROR is absorbing until reset: imem_req=0, instr_valid=0, fetch_err=1.
REQ-029 imem_ack SHALL be ignored outside FETCH.
REQ-030 instr_ready SHALL be ignored outside HOLD.
REQ-031 Redirect inputs SHALL be sampled only in the HOLD cycle where instr_ready=1.
REQ-032 Steady-state throughput: one instruction per 2 cycles plus memory wait cycles. An ack in the first FETCH cycle gives the minimum.

Reset
REQ-033 Reset SHALL force: state=FETCH, fetch PC=RESET_PC, pc=RESET_PC, instr=0, fetch_err=0. It acts immediately and asynchronously.
REQ-034 While reset=1: imem_req=0 and instr_valid=0. The first request SHALL go out in the first cycle after reset deasserts.
REQ-035 Reset asserted mid-request (FETCH awaiting ack, or an ack in the same cycle) SHALL win. The in-flight response SHALL be discarded.

Structure
REQ-036 A shared package SHALL hold the state enum (FETCH, HOLD, ERROR), the INSTR_W=32 constant and the RESET_PC default.
REQ-037 Next-PC selection SHALL live in one combinational sub-module, nextpc, which also produces the misalignment flag. Registers and the FSM SHALL stay in fetch_unit.

Verification
REQ-038 Sequential fetch: reset, then memory acks after 0 wait cycles returning 0x20080005, instr_ready held at 1.
- Required: requests at addresses 0x0, 0x4, 0x8.
- Required: op=0x08 on each delivered instruction.
REQ-039 Branch: held pc=0x10, pcsrc=1, signimm=0xFFFFFFFE, consumed.
- Required: next imem_addr=0x0C.
REQ-040 Jump priority: held pc=0x20, instr=0x08000040, jump=1, pcsrc=1.
- Required: next imem_addr=0x100, so jump beats pcsrc.
REQ-041 Jump register misaligned: jumpreg=1, rs_data=0x102.
- Required: ERROR state, fetch_err=1, pc=0x102.
- Required: no further imem_req until reset.
REQ-042 Backpressure and wait states:
- Memory delays ack by 3 cycles: imem_addr stays stable throughout.
- instr_ready low for 4 cycles: instr and pc stay stable.
- Ack while in HOLD: no state change.
REQ-043 Reset in the ack cycle of address 0x8:
- Required: instr_valid=0 next cycle.
- Required: first post-reset request addresses RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction word width and the default reset fetch address.
package fetch_unit_pkg;

   localparam int INSTR_W = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      ERROR = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/nextpc.sv
// Combinational next-PC selection for the held instruction, plus a flag
// telling the fetch FSM that the chosen target is not word aligned.
module nextpc
   import fetch_unit_pkg::*;
#(
   parameter int n = 32
) (
   input  logic [n-1:0] i_pcPlus4,
   input  logic [25:0]  i_jTarget,
   input  logic [n-1:0] i_signImm,
   input  logic [n-1:0] i_rsData,
   input  logic         i_pcSrc,
   input  logic         i_jump,
   input  logic         i_jumpReg,
   output logic [n-1:0] o_nextPc,
   output logic         o_misaligned
);

   // Jump-register outranks jump, which outranks a taken branch.
   always_comb begin
      o_nextPc = i_pcPlus4;
      if (i_jumpReg) begin
         o_nextPc = i_rsData;
      end else if (i_jump) begin
         o_nextPc = {i_pcPlus4[n-1:28], i_jTarget, 2'b00};
      end else if (i_pcSrc) begin
         o_nextPc = i_pcPlus4 + (i_signImm << 2);
      end
   end

   assign o_misaligned = |o_nextPc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for the decoder, then redirects to the next PC.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          n        = 32,
   parameter logic [n-1:0] RESET_PC = n'(RESET_PC_DEFAULT)
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [n-1:0]       imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ack,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [5:0]         op,
   output logic [5:0]         funct,
   output logic [n-1:0]       pc,
   output logic [n-1:0]       pcplus4,
   input  logic               pcsrc,
   input  logic               jump,
   input  logic               jumpreg,
   input  logic [n-1:0]       signimm,
   input  logic [n-1:0]       rs_data,
   output logic               fetch_err
);

   fetch_state_e       r_state;
   logic [n-1:0]       r_fetchPc;
   logic [n-1:0]       r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_err;

   logic [n-1:0]       w_pcPlus4;
   logic [n-1:0]       w_nextPc;
   logic               w_misaligned;

   assign w_pcPlus4 = r_pc + n'(4);

   nextpc #(.n(n)) u_nextpc (
      .i_pcPlus4    (w_pcPlus4),
      .i_jTarget    (r_instr[25:0]),
      .i_signImm    (signimm),
      .i_rsData     (rs_data),
      .i_pcSrc      (pcsrc),
      .i_jump       (jump),
      .i_jumpReg    (jumpreg),
      .o_nextPc     (w_nextPc),
      .o_misaligned (w_misaligned)
   );

   // Reset gates the request so nothing leaves while reset is still high.
   assign imem_req    = (r_state == FETCH) && !reset;
   assign imem_addr   = r_fetchPc;
   assign instr_valid = (r_state == HOLD) && !reset;
   assign instr       = r_instr;
   assign op          = r_instr[31:26];
   assign funct       = r_instr[5:0];
   assign pc          = r_pc;
   assign pcplus4     = w_pcPlus4;
   assign fetch_err   = r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= FETCH;
         r_fetchPc <= RESET_PC;
         r_pc      <= RESET_PC;
         r_instr   <= '0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               if (imem_ack) begin
                  r_instr <= imem_rdata;
                  r_pc    <= r_fetchPc;
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  if (w_misaligned) begin
                     r_pc    <= w_nextPc;
                     r_err   <= 1'b1;
                     r_state <= ERROR;
                  end else begin
                     r_fetchPc <= w_nextPc;
                     r_state   <= FETCH;
                  end
               end
            end
            ERROR: begin
               r_state <= ERROR;
            end
            default: begin
               r_state <= ERROR;
               r_err   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential fetch, branch, jump
// priority, misaligned jump-register, wait states, backpressure and reset.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pcplus4;
   logic        pcsrc;
   logic        jump;
   logic        jumpreg;
   logic [31:0] signimm;
   logic [31:0] rs_data;
   logic        fetch_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] lastInstr;
   logic [31:0] lastAddr;

   always #5 clk = ~clk;

   fetch_unit #(.n(32), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ack    (imem_ack),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .op          (op),
      .funct       (funct),
      .pc          (pc),
      .pcplus4     (pcplus4),
      .pcsrc       (pcsrc),
      .jump        (jump),
      .jumpreg     (jumpreg),
      .signimm     (signimm),
      .rs_data     (rs_data),
      .fetch_err   (fetch_err)
   );

   // Single comparison point: counts every check and reports any miss.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      checks++;
      assert (obs === expd) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expd);
      end
   endtask

   // Serve one fetch at addr after the given number of wait cycles.
   task automatic fetchInstr(input logic [31:0] addr, input int waits, input logic [31:0] data);
      logic [31:0] expPlus4;
      for (int i = 0; i <= waits; i++) begin
         checkOutput("fetch_req", 32'(imem_req), 32'd1);
         checkOutput("fetch_addr", imem_addr, addr);
         checkOutput("fetch_valid_low", 32'(instr_valid), 32'd0);
         imem_ack   = (i == waits);
         imem_rdata = (i == waits) ? data : 32'hDEAD_BEEF;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      expPlus4 = addr + 32'd4;
      checkOutput("hold_valid", 32'(instr_valid), 32'd1);
      checkOutput("hold_req_low", 32'(imem_req), 32'd0);
      checkOutput("hold_instr", instr, data);
      checkOutput("hold_pc", pc, addr);
      checkOutput("hold_pcplus4", pcplus4, expPlus4);
      checkOutput("hold_op", 32'(op), 32'(data[31:26]));
      checkOutput("hold_funct", 32'(funct), 32'(data[5:0]));
      lastInstr = data;
      lastAddr  = addr;
   endtask

   // Stall the decoder for a while (with stray acks and junk redirects), then consume.
   task automatic applyStimulus(input int stall, input logic jr, input logic j, input logic ps,
                                input logic [31:0] simm, input logic [31:0] rs);
      instr_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'h1234_5678;
         jumpreg    = 1'b1;
         rs_data    = 32'h0000_0555;
         @(negedge clk);
         checkOutput("stall_valid", 32'(instr_valid), 32'd1);
         checkOutput("stall_req_low", 32'(imem_req), 32'd0);
         checkOutput("stall_instr", instr, lastInstr);
         checkOutput("stall_pc", pc, lastAddr);
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      jumpreg     = jr;
      jump        = j;
      pcsrc       = ps;
      signimm     = simm;
      rs_data     = rs;
      @(negedge clk);
      jumpreg = 1'b0;
      jump    = 1'b0;
      pcsrc   = 1'b0;
      signimm = 32'h0;
      rs_data = 32'h0;
   endtask

   initial begin
      reset       = 1'b1;
      imem_rdata  = 32'h0;
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      pcsrc       = 1'b0;
      jump        = 1'b0;
      jumpreg     = 1'b0;
      signimm     = 32'h0;
      rs_data     = 32'h0;
      lastInstr   = 32'h0;
      lastAddr    = 32'h0;

      $display("[TB] reset state");
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_req", 32'(imem_req), 32'd0);
      checkOutput("rst_valid", 32'(instr_valid), 32'd0);
      checkOutput("rst_err", 32'(fetch_err), 32'd0);
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_instr", instr, 32'h0);
      reset = 1'b0;
      #1;
      checkOutput("first_req", 32'(imem_req), 32'd1);
      checkOutput("first_addr", imem_addr, 32'h0);

      $display("[TB] sequential fetch up to 0x10");
      for (int a = 0; a < 16; a += 4) begin
         fetchInstr(32'(a), 0, 32'h2008_0005);
         applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      fetchInstr(32'h10, 0, 32'h2008_0005);

      $display("[TB] branch back from 0x10");
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0);

      $display("[TB] walk to 0x20 then jump with pcsrc also set");
      for (int a = 12; a < 32; a += 4) begin
         fetchInstr(32'(a), 0, 32'h0000_0020);
         applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      fetchInstr(32'h20, 0, 32'h0800_0040);
      applyStimulus(0, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0);

      $display("[TB] wait states and backpressure");
      fetchInstr(32'h100, 3, 32'h2008_0005);
      applyStimulus(4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      fetchInstr(32'h104, 0, 32'h8C01_002A);

      $display("[TB] misaligned jump register");
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0102);
      checkOutput("err_flag", 32'(fetch_err), 32'd1);
      checkOutput("err_pc", pc, 32'h0000_0102);
      checkOutput("err_req", 32'(imem_req), 32'd0);
      checkOutput("err_valid", 32'(instr_valid), 32'd0);
      imem_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("err_stay_req", 32'(imem_req), 32'd0);
         checkOutput("err_stay_valid", 32'(instr_valid), 32'd0);
         checkOutput("err_stay_flag", 32'(fetch_err), 32'd1);
      end
      imem_ack = 1'b0;

      $display("[TB] reset clears error, then reset during ack of 0x8");
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst2_err", 32'(fetch_err), 32'd0);
      checkOutput("rst2_pc", pc, 32'h0);
      reset = 1'b0;
      #1;
      fetchInstr(32'h0, 0, 32'h2008_0005);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      fetchInstr(32'h4, 0, 32'h2008_0005);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("pre_rst_addr", imem_addr, 32'h8);
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      reset      = 1'b1;
      @(negedge clk);
      checkOutput("rst_ack_valid", 32'(instr_valid), 32'd0);
      checkOutput("rst_ack_req", 32'(imem_req), 32'd0);
      checkOutput("rst_ack_instr", instr, 32'h0);
      imem_ack = 1'b0;
      reset    = 1'b0;
      #1;
      checkOutput("post_rst_req", 32'(imem_req), 32'd1);
      checkOutput("post_rst_addr", imem_addr, 32'h0);
      fetchInstr(32'h0, 1, 32'h0000_0021);

      $display("[TB] address wrap at top of memory");
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
      fetchInstr(32'hFFFF_FFFC, 0, 32'h2008_0005);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      fetchInstr(32'h0, 0, 32'h2008_0005);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
